// File: rtl/mem_map_pkg.sv
// Shared definitions for the CPU memory router: request FSM states,
// the default I/O window base and the register-index width helper.
package mem_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAM_BUSY = 2'd1,
    ST_IO_CPLT   = 2'd2
  } mem_state_e;

  localparam logic [15:0] MEM_IO_BASE_DEFAULT = 16'h0100;

  // Width of an I/O register index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_reg_bank.sv
// Bank of NUM_IO memory-mapped I/O registers with one-cycle write strobes.
// The read mux exists only when IO_READBACK_EN is defined.
module io_reg_bank #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    NUM_IO     = 4,
  parameter int                    IW         = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we_i,
  input  logic [IW-1:0]                widx_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
`ifdef IO_READBACK_EN
  input  logic [IW-1:0]                ridx_i,
  output logic [DATA_WIDTH-1:0]        rdata_o,
`endif
  output logic [NUM_IO*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_IO-1:0]            strobe_o
);

  logic [NUM_IO*DATA_WIDTH-1:0] regs_q;
  logic [NUM_IO-1:0]            strobe_q;

  // Register update and strobe generation; strobe is high the cycle after a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= {NUM_IO{RESET_VAL}};
      strobe_q <= '0;
    end else begin
      for (int k = 0; k < NUM_IO; k++) begin
        strobe_q[k] <= we_i && (widx_i == IW'(k));
        if (we_i && (widx_i == IW'(k))) begin
          regs_q[k*DATA_WIDTH +: DATA_WIDTH] <= wdata_i;
        end
      end
    end
  end

`ifdef IO_READBACK_EN
  // Read mux selecting the addressed register.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (ridx_i == IW'(k)) rdata_o = regs_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end
`endif

  assign regs_o   = regs_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/mem_io_router.sv
// Routes CPU memory requests to the SDRAM driver or to the I/O register
// window [IO_BASE, IO_BASE+NUM_IO). One transaction is outstanding at a time.
// Optional feature macro: IO_READBACK_EN (I/O reads return register data;
// otherwise they complete with zero data).
//
// Handshake: a request is taken when mem_rdy=1 and mem_r_en|mem_w_en=1 in the
// same cycle (read wins if both are set); enables are ignored while
// mem_rdy=0, and mem_cplt pulses once per accepted request.
module mem_io_router
  import mem_map_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    NUM_IO       = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE      = ADDR_WIDTH'(MEM_IO_BASE_DEFAULT),
  parameter logic [DATA_WIDTH-1:0] IO_RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_data_in,
  input  logic                         mem_r_en,
  input  logic                         mem_w_en,
  output logic                         mem_rdy,
  output logic                         mem_cplt,
  output logic [DATA_WIDTH-1:0]        mem_data_out,
  output logic [ADDR_WIDTH-1:0]        dram_addr,
  output logic [DATA_WIDTH-1:0]        dram_data_in,
  output logic                         dram_r_en,
  output logic                         dram_w_en,
  input  logic                         dram_rdy,
  input  logic                         dram_cplt,
  input  logic [DATA_WIDTH-1:0]        dram_data_out,
  output logic [NUM_IO*DATA_WIDTH-1:0] io_regs,
  output logic [NUM_IO-1:0]            io_wr_strobe,
  output logic [1:0]                   dbg_state
);

  localparam int IW = idx_width(NUM_IO);

  mem_state_e state_q, state_d;

  logic [ADDR_WIDTH:0] addr_ext, io_lo, io_hi;
  logic                io_hit;
  logic [IW-1:0]       io_idx;
  logic                accept;
  logic                rd_req, wr_req;
  logic                io_we;

  // Extended-width compare so IO_BASE+NUM_IO cannot wrap.
  assign addr_ext = {1'b0, mem_addr};
  assign io_lo    = {1'b0, IO_BASE};
  assign io_hi    = io_lo + (ADDR_WIDTH+1)'(NUM_IO);
  assign io_hit   = (addr_ext >= io_lo) && (addr_ext < io_hi);
  assign io_idx   = IW'(mem_addr - IO_BASE);

  assign mem_rdy = (state_q == ST_IDLE) && dram_rdy;
  assign rd_req  = mem_r_en;
  assign wr_req  = mem_w_en && !mem_r_en;
  assign accept  = mem_rdy && (mem_r_en || mem_w_en);
  assign io_we   = accept && io_hit && wr_req;

  assign dram_addr    = mem_addr;
  assign dram_data_in = mem_data_in;
  assign dram_r_en    = accept && !io_hit && rd_req;
  assign dram_w_en    = accept && !io_hit && wr_req;

  // Request FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_d = io_hit ? ST_IO_CPLT : ST_DRAM_BUSY;
      ST_DRAM_BUSY: if (dram_cplt) state_d = ST_IDLE;
      ST_IO_CPLT:   state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign dbg_state = state_q;

`ifdef IO_READBACK_EN
  logic          rd_q;
  logic [IW-1:0] idx_q;
  logic [DATA_WIDTH-1:0] bank_rdata;

  // Latch the type and index of an accepted I/O request for the completion cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= 1'b0;
      idx_q <= '0;
    end else if (accept && io_hit) begin
      rd_q  <= rd_req;
      idx_q <= io_idx;
    end
  end
`endif

  io_reg_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_IO    (NUM_IO),
    .IW        (IW),
    .RESET_VAL (IO_RESET_VAL)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (io_we),
    .widx_i  (io_idx),
    .wdata_i (mem_data_in),
`ifdef IO_READBACK_EN
    .ridx_i  (idx_q),
    .rdata_o (bank_rdata),
`endif
    .regs_o  (io_regs),
    .strobe_o(io_wr_strobe)
  );

  // Completion and read-data steering; no register stage on the DRAM path.
  always_comb begin
    mem_cplt     = 1'b0;
    mem_data_out = '0;
    case (state_q)
      ST_DRAM_BUSY: begin
        mem_cplt     = dram_cplt;
        mem_data_out = dram_data_out;
      end
      ST_IO_CPLT: begin
        mem_cplt = 1'b1;
`ifdef IO_READBACK_EN
        mem_data_out = rd_q ? bank_rdata : '0;
`else
        mem_data_out = '0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_io_router.sv
// Directed bench for mem_io_router: I/O writes/reads, DRAM latency,
// read-wins collision, window boundaries, dram_rdy gating and reset abort.
module tb_mem_io_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_r_en, mem_w_en;
  logic        mem_rdy, mem_cplt;
  logic [15:0] mem_data_out;
  logic [15:0] dram_addr, dram_data_in;
  logic        dram_r_en, dram_w_en;
  logic        dram_rdy, dram_cplt;
  logic [15:0] dram_data_out;
  logic [63:0] io_regs;
  logic [3:0]  io_wr_strobe;
  logic [1:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] exp_rd;

  mem_io_router dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .mem_rdy      (mem_rdy),
    .mem_cplt     (mem_cplt),
    .mem_data_out (mem_data_out),
    .dram_addr    (dram_addr),
    .dram_data_in (dram_data_in),
    .dram_r_en    (dram_r_en),
    .dram_w_en    (dram_w_en),
    .dram_rdy     (dram_rdy),
    .dram_cplt    (dram_cplt),
    .dram_data_out(dram_data_out),
    .io_regs      (io_regs),
    .io_wr_strobe (io_wr_strobe),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    dram_cplt = 1'b0;
  endtask

  initial begin
`ifdef IO_READBACK_EN
    exp_rd = 16'h1234;
`else
    exp_rd = 16'h0000;
`endif
    rst_n = 1'b0; mem_addr = '0; mem_data_in = '0;
    dram_rdy = 1'b1; dram_data_out = '0;
    idle_inputs();
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_cplt", 64'(mem_cplt), 64'd0);
    chk("rst_data", 64'(mem_data_out), 64'd0);
    chk("rst_regs", io_regs, 64'd0);
    chk("rst_strobe", 64'(io_wr_strobe), 64'd0);
    chk("rst_rdy", 64'(mem_rdy), 64'd1);
    chk("rst_state", 64'(dbg_state), 64'd0);

    // I/O write 0x1234 to register 2
    step();
    mem_addr = 16'h0102; mem_data_in = 16'h1234; mem_w_en = 1'b1;
    #1;
    chk("iow_dram_w", 64'(dram_w_en), 64'd0);
    chk("iow_dram_r", 64'(dram_r_en), 64'd0);
    step(); idle_inputs(); #1;
    chk("iow_cplt", 64'(mem_cplt), 64'd1);
    chk("iow_data", 64'(mem_data_out), 64'd0);
    chk("iow_reg2", 64'(io_regs[32 +: 16]), 64'h1234);
    chk("iow_strobe", 64'(io_wr_strobe), 64'b0100);
    chk("iow_rdy_busy", 64'(mem_rdy), 64'd0);
    step(); #1;
    chk("iow_cplt_off", 64'(mem_cplt), 64'd0);
    chk("iow_strobe_off", 64'(io_wr_strobe), 64'd0);
    chk("iow_rdy_back", 64'(mem_rdy), 64'd1);

    // I/O read register 2
    mem_addr = 16'h0102; mem_r_en = 1'b1;
    step(); idle_inputs(); #1;
    chk("ior_cplt", 64'(mem_cplt), 64'd1);
    chk("ior_data", 64'(mem_data_out), 64'(exp_rd));
    step();

    // DRAM read 0x0040, 5-cycle driver latency
    mem_addr = 16'h0040; mem_r_en = 1'b1;
    #1;
    chk("dr_r_en", 64'(dram_r_en), 64'd1);
    chk("dr_addr", 64'(dram_addr), 64'h0040);
    for (int i = 1; i <= 4; i++) begin
      step(); idle_inputs(); #1;
      chk("dr_rdy_low", 64'(mem_rdy), 64'd0);
      chk("dr_no_cplt", 64'(mem_cplt), 64'd0);
      chk("dr_r_en_off", 64'(dram_r_en), 64'd0);
    end
    step();
    dram_cplt = 1'b1; dram_data_out = 16'hBEEF;
    #1;
    chk("dr_rdy_low5", 64'(mem_rdy), 64'd0);
    chk("dr_cplt", 64'(mem_cplt), 64'd1);
    chk("dr_data", 64'(mem_data_out), 64'hBEEF);
    step(); idle_inputs(); #1;
    chk("dr_rdy_back", 64'(mem_rdy), 64'd1);
    chk("dr_cplt_off", 64'(mem_cplt), 64'd0);

    // Both enables to IO_BASE: read, register 0 unchanged, no strobe
    mem_addr = 16'h0100; mem_data_in = 16'hFFFF; mem_r_en = 1'b1; mem_w_en = 1'b1;
    #1;
    chk("both_dram_w", 64'(dram_w_en), 64'd0);
    step(); idle_inputs(); #1;
    chk("both_cplt", 64'(mem_cplt), 64'd1);
    chk("both_reg0", 64'(io_regs[0 +: 16]), 64'h0000);
    chk("both_strobe", 64'(io_wr_strobe), 64'd0);
    chk("both_data", 64'(mem_data_out), 64'd0);
    step();

    // Boundary: IO_BASE-1 goes to DRAM
    mem_addr = 16'h00FF; mem_r_en = 1'b1;
    #1;
    chk("lo_dram_r", 64'(dram_r_en), 64'd1);
    step(); idle_inputs();
    dram_cplt = 1'b1; dram_data_out = 16'h5A5A;
    #1;
    chk("lo_cplt", 64'(mem_cplt), 64'd1);
    chk("lo_data", 64'(mem_data_out), 64'h5A5A);
    step(); idle_inputs();

    // Boundary: IO_BASE+NUM_IO goes to DRAM as a write
    mem_addr = 16'h0104; mem_data_in = 16'h7777; mem_w_en = 1'b1;
    #1;
    chk("hi_dram_w", 64'(dram_w_en), 64'd1);
    chk("hi_dram_d", 64'(dram_data_in), 64'h7777);
    step(); idle_inputs(); #1;
    chk("hi_state_busy", 64'(dbg_state), 64'd1);
    chk("hi_strobe", 64'(io_wr_strobe), 64'd0);
    dram_cplt = 1'b1; #1;
    chk("hi_cplt", 64'(mem_cplt), 64'd1);
    step(); idle_inputs();

    // Boundary: IO_BASE+NUM_IO-1 is the last I/O register
    mem_addr = 16'h0103; mem_data_in = 16'hABCD; mem_w_en = 1'b1;
    #1;
    chk("top_dram_w", 64'(dram_w_en), 64'd0);
    step(); idle_inputs(); #1;
    chk("top_reg3", 64'(io_regs[48 +: 16]), 64'hABCD);
    chk("top_strobe", 64'(io_wr_strobe), 64'b1000);
    chk("top_reg2_kept", 64'(io_regs[32 +: 16]), 64'h1234);
    step();

    // dram_rdy low: not ready, request ignored
    dram_rdy = 1'b0; mem_addr = 16'h0040; mem_r_en = 1'b1;
    #1;
    chk("nrdy_rdy", 64'(mem_rdy), 64'd0);
    chk("nrdy_dram_r", 64'(dram_r_en), 64'd0);
    step(); idle_inputs(); dram_rdy = 1'b1; #1;
    chk("nrdy_state", 64'(dbg_state), 64'd0);
    chk("nrdy_cplt", 64'(mem_cplt), 64'd0);

    // Reset during DRAM_BUSY, then a late dram_cplt
    mem_addr = 16'h0200; mem_r_en = 1'b1;
    step(); idle_inputs(); #1;
    chk("rb_state_busy", 64'(dbg_state), 64'd1);
    rst_n = 1'b0; #1;
    chk("rb_cplt", 64'(mem_cplt), 64'd0);
    chk("rb_regs", io_regs, 64'd0);
    chk("rb_state", 64'(dbg_state), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    dram_cplt = 1'b1; dram_data_out = 16'hDEAD; #1;
    chk("late_cplt", 64'(mem_cplt), 64'd0);
    chk("late_data", 64'(mem_data_out), 64'd0);
    step(); idle_inputs(); #1;
    chk("late_state", 64'(dbg_state), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_io_router.md
# mem_io_router

Routes CPU-side memory requests either to the SDRAM driver or to a bank of `NUM_IO` memory-mapped I/O registers, chosen by address decode. It sits between the CPU memory port and `mem_driver`, and replaces the single hard-wired display register with a parametrised I/O window. A small request FSM ensures exactly one transaction is outstanding at a time, so completions and read data are never misrouted.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: CPU address width.
- `DATA_WIDTH`, 16: data width of the CPU, DRAM and I/O registers.
- `NUM_IO`, 4: number of I/O registers. Power of two, 1..16.
- `IO_BASE`, 16'h0100: first I/O address. Must be aligned to `NUM_IO`.
- `IO_RESET_VAL`, 0: reset value of every I/O register.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `mem_addr`  in  ADDR_WIDTH: request address.
- `mem_data_in`  in  DATA_WIDTH: write data.
- `mem_r_en`, `mem_w_en`  in  1: request pulses, sampled only while `mem_rdy`=1.
- `mem_rdy`  out  1: ready to accept a request.
- `mem_cplt`  out  1: one-cycle completion pulse.
- `mem_data_out`  out  DATA_WIDTH: read data, valid while `mem_cplt`=1.
- `dram_addr`, `dram_data_in`  out  ADDR_WIDTH/DATA_WIDTH: passthrough of `mem_addr` and `mem_data_in`.
- `dram_r_en`, `dram_w_en`  out  1: gated request to the driver.
- `dram_rdy`, `dram_cplt`  in  1: driver handshake.
- `dram_data_out`  in  DATA_WIDTH: driver read data.
- `io_regs`  out  NUM_IO*DATA_WIDTH: flattened register contents; register k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `io_wr_strobe`  out  NUM_IO: one-cycle pulse after register k is written.

## Operation
- Address decode: `io_hit` = (`mem_addr` >= `IO_BASE`) and (`mem_addr` < `IO_BASE`+`NUM_IO`). Register index = `mem_addr` minus `IO_BASE`, truncated to clog2(`NUM_IO`) bits (minimum 1).
- A request is accepted when `mem_rdy`=1 and (`mem_r_en` or `mem_w_en`) is 1. If both enables are high, the request is a read and the write is dropped.
- `mem_rdy` = (state==IDLE) and `dram_rdy`.
- FSM states:
  - IDLE:
    - Accepted I/O hit: latch the read/write type and index. A write updates the register at this edge. Go to IO_CPLT.
    - Accepted DRAM access: `dram_r_en`/`dram_w_en` equal the gated CPU enables combinationally in the same cycle. Go to DRAM_BUSY.
    - Otherwise stay in IDLE.
  - DRAM_BUSY: `mem_cplt` = `dram_cplt` and `mem_data_out` = `dram_data_out`. On `dram_cplt`, go to IDLE.
  - IO_CPLT: `mem_cplt`=1 for one cycle. For reads, `mem_data_out` = latched register. For writes, `mem_data_out` = 0. Go to IDLE.
- `dram_r_en`/`dram_w_en` are 0 except in an accepting IDLE cycle for a non-I/O address.
- `dram_cplt` seen in IDLE or IO_CPLT is ignored and not forwarded.
- Requests while `mem_rdy`=0 are ignored; no queueing.

## Timing
- Reset values: state IDLE; `mem_cplt` 0; `mem_data_out` 0; `io_regs` all `IO_RESET_VAL`; `io_wr_strobe` 0.
- `mem_rdy` follows `dram_rdy` while in IDLE.
- I/O latency: `mem_cplt` high exactly 1 cycle after acceptance. `io_regs` and `io_wr_strobe` update on the same edge that enters IO_CPLT.
- DRAM latency equals driver latency plus 0 cycles. The router adds no register stage on the request or completion path.
- The earliest next acceptance is the cycle after `mem_cplt`.
- Reset mid-transaction returns to IDLE immediately. An outstanding DRAM access is abandoned; the driver shares `rst_n`.
- A write to a register whose index is outside 0..`NUM_IO`-1 cannot occur, by construction of the decode.

## Configuration
- `IO_READBACK_EN` defined: I/O reads return the addressed register value.
- `IO_READBACK_EN` undefined: I/O reads complete with the same 1-cycle latency but return 0. The read mux and index latch are not built.

## Structure
- Package `mem_map_pkg` holds:
  - the state enum typedef (IDLE, DRAM_BUSY, IO_CPLT);
  - the default `IO_BASE` constant;
  - the index-width function.
- Sub-module `io_reg_bank`: `NUM_IO` registers with write enable, index, write data, strobes and the optional read mux.

## Test plan
- Write 16'h1234 to `IO_BASE`+2 (with `dram_rdy`=1) -> `dram_w_en` stays 0; next cycle `mem_cplt`=1, register 2 = 16'h1234, `io_wr_strobe`=4'b0100.
- With `IO_READBACK_EN` defined, read `IO_BASE`+2 -> `mem_data_out`=16'h1234 together with `mem_cplt`. With the macro undefined, the same read returns 0.
- Read 16'h0040 while the DRAM model returns 16'hBEEF after 5 cycles -> `dram_r_en` pulses in the accept cycle; `mem_rdy`=0 for 5 cycles; `mem_cplt`=1 with 16'hBEEF; next cycle `mem_rdy`=1.
- Both `mem_r_en` and `mem_w_en` high to `IO_BASE` -> handled as a read; register unchanged; no strobe.
- Boundary addresses: `IO_BASE`-1 and `IO_BASE`+`NUM_IO` go to DRAM; `IO_BASE`+`NUM_IO`-1 goes to I/O.
- Assert `rst_n` low during DRAM_BUSY -> `mem_cplt`=0, all `io_regs`=`IO_RESET_VAL`; after release, a late `dram_cplt` pulse is not forwarded.
